// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared state encoding and latency helper for the divider core
// Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Cycles from operand acceptance to o_valid for a non-zero divisor.
  function automatic int div_latency(input int n);
    return 2 * n + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one restoring-division iteration (shift, compare, subtract)
// Rev 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic [IN_DATA_WIDTH:0]   rem,
  input  logic                     q_msb,
  input  logic [IN_DATA_WIDTH-1:0] divisor,
  output logic [IN_DATA_WIDTH:0]   next_rem,
  output logic                     q_bit
);

  localparam int N = IN_DATA_WIDTH;

  logic [N:0] w_t;
  logic [N:0] w_divisor_ext;
  logic       w_ge;
  logic       w_unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit stays 0
  // and the shifted value still fits in N+1 bits.
  assign w_t              = {rem[N-1:0], q_msb};
  assign w_divisor_ext    = {1'b0, divisor};
  assign w_ge             = (w_t >= w_divisor_ext);
  assign next_rem         = w_ge ? (w_t - w_divisor_ext) : w_t;
  assign q_bit            = w_ge;
  assign w_unused_rem_msb = rem[N];

endmodule

`default_nettype wire

// File: rtl/div_core.sv
// ============================================================================
// div_core : multi-cycle unsigned restoring divider, 2N/N -> 2N quotient, N rem
// Rev 1.0
// ============================================================================
`default_nettype none

module div_core
  import div_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [2*IN_DATA_WIDTH-1:0] i_dividend,
  input  logic [IN_DATA_WIDTH-1:0]   i_divisor,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [2*IN_DATA_WIDTH-1:0] o_quotient,
  output logic [IN_DATA_WIDTH-1:0]   o_remainder,
  output logic                       o_div_by_zero
);

  localparam int N     = IN_DATA_WIDTH;
  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(2 * N - 1);

  div_state_t       r_state;
  logic [2*N-1:0]   r_q;
  logic [N:0]       r_rem;
  logic [N-1:0]     r_divisor;
  logic [CNT_W-1:0] r_count;
  logic             r_dbz;

  logic [N:0]       w_next_rem;
  logic             w_q_bit;
  logic             w_unused_rem_msb;

  assign w_unused_rem_msb = r_rem[N];

  div_step #(
    .IN_DATA_WIDTH (N)
  ) u_div_step (
    .rem      (r_rem),
    .q_msb    (r_q[2*N-1]),
    .divisor  (r_divisor),
    .next_rem (w_next_rem),
    .q_bit    (w_q_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_q           <= '0;
      r_rem         <= '0;
      r_divisor     <= '0;
      r_count       <= '0;
      r_dbz         <= 1'b0;
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            o_ready   <= 1'b0;
            r_divisor <= i_divisor;
            if (i_divisor == '0) begin
              // Divide by zero skips iteration; result is staged directly.
              r_q     <= '1;
              r_rem   <= {1'b0, i_dividend[N-1:0]};
              r_dbz   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_q     <= i_dividend;
              r_rem   <= '0;
              r_dbz   <= 1'b0;
              r_count <= C_CNT_INIT;
              r_state <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          r_q   <= {r_q[2*N-2:0], w_q_bit};
          r_rem <= w_next_rem;
          if (r_count == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end

        ST_DONE: begin
          // First DONE cycle publishes the result; i_ready counts only once valid.
          if (!o_valid) begin
            o_valid       <= 1'b1;
            o_quotient    <= r_q;
            o_remainder   <= r_rem[N-1:0];
            o_div_by_zero <= r_dbz;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
